// File: rtl/dcache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_ctrl_if
// Description : Lookup, memory-read, data-array and tag/valid-array signals
//               of the Dcache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int TAG_WIDTH  = 25,
    parameter int WORD_W     = 1,
    parameter int WAY        = 2
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [WAY-1:0]        hit;
    logic                  stall;
    logic                  mem_rd_req;
    logic [31:0]           mem_rd_addr;
    logic                  mem_rd_ready;
    logic                  mem_rd_valid;
    logic [31:0]           mem_rd_data;
    logic                  data_we;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [WORD_W-1:0]     data_offset;
    logic [31:0]           data_din;
    logic                  data_way_select;
    logic                  TagV_we;
    logic [ADDR_WIDTH-1:0] TagV_addr_write;
    logic [TAG_WIDTH:0]    TagV_din_write;
    logic                  TagV_way_select;
    logic                  refill_done;

    modport master (
        input  req_valid, req_index, req_tag, hit,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data,
        output stall, mem_rd_req, mem_rd_addr,
        output data_we, data_addr, data_offset, data_din, data_way_select,
        output TagV_we, TagV_addr_write, TagV_din_write, TagV_way_select,
        output refill_done
    );

    modport slave (
        output req_valid, req_index, req_tag, hit,
        output mem_rd_ready, mem_rd_valid, mem_rd_data,
        input  stall, mem_rd_req, mem_rd_addr,
        input  data_we, data_addr, data_offset, data_din, data_way_select,
        input  TagV_we, TagV_addr_write, TagV_din_write, TagV_way_select,
        input  refill_done
    );
endinterface
`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_ctrl
// Description : Write-through 2-way Dcache miss handler with per-set LRU bit.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_refill_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int TAG_WIDTH  = 25,
    parameter int LINE_WORDS = 2,
    parameter int WAY        = 2
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    dcache_refill_ctrl_if.master bus
);
    localparam int c_WORD_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int c_OFFSET_W = $clog2(LINE_WORDS * 4);
    localparam int c_SETS     = 1 << ADDR_WIDTH;
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [c_SETS-1:0]     r_lru;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_victim;
    logic [c_WORD_W-1:0]   r_count;
    logic                  r_dataWe;
    logic [ADDR_WIDTH-1:0] r_dataAddr;
    logic [c_WORD_W-1:0]   r_dataOffset;
    logic [31:0]           r_dataDin;
    logic                  r_dataWay;

    logic w_miss;
    logic w_hit;
    logic w_word;
    logic w_fill;

    assign w_miss = bus.req_valid & (bus.hit == '0);
    assign w_hit  = bus.req_valid & (|bus.hit);
    assign w_word = (r_state == S_RECV) & bus.mem_rd_valid;
    assign w_fill = (r_state == S_FILL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_nextState = S_REQ;
            S_REQ:   if (bus.mem_rd_ready) w_nextState = S_RECV;
            S_RECV:  if (w_word && r_count == c_LAST_WORD) w_nextState = S_FILL;
            S_FILL:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lru        <= '0;
            r_index      <= '0;
            r_tag        <= '0;
            r_victim     <= 1'b0;
            r_count      <= '0;
            r_dataWe     <= 1'b0;
            r_dataAddr   <= '0;
            r_dataOffset <= '0;
            r_dataDin    <= '0;
            r_dataWay    <= 1'b0;
        end else begin
            r_dataWe <= w_word;
            if (w_word) begin
                r_dataAddr   <= r_index;
                r_dataOffset <= r_count;
                r_dataDin    <= bus.mem_rd_data;
                r_dataWay    <= r_victim;
                r_count      <= r_count + 1'b1;
            end
            if (r_state == S_IDLE) begin
                if (w_miss) begin
                    r_index  <= bus.req_index;
                    r_tag    <= bus.req_tag;
                    r_victim <= r_lru[bus.req_index];
                    r_count  <= '0;
                end else if (w_hit) begin
                    // LRU bit names the victim: the way just used is protected;
                    // a multi-hit counts as a use of the highest way.
                    r_lru[bus.req_index] <= ~bus.hit[WAY-1];
                end
            end
            if (w_fill) r_lru[r_index] <= ~r_victim;
        end
    end

    assign bus.stall           = (r_state != S_IDLE) | w_miss;
    assign bus.mem_rd_req      = (r_state == S_REQ);
    assign bus.mem_rd_addr     = (r_state == S_REQ) ? {r_tag, r_index, {c_OFFSET_W{1'b0}}} : 32'd0;
    assign bus.data_we         = r_dataWe;
    assign bus.data_addr       = r_dataAddr;
    assign bus.data_offset     = r_dataOffset;
    assign bus.data_din        = r_dataDin;
    assign bus.data_way_select = r_dataWay;
    assign bus.TagV_we         = w_fill;
    assign bus.TagV_addr_write = w_fill ? r_index : '0;
    assign bus.TagV_din_write  = w_fill ? {1'b1, r_tag} : '0;
    assign bus.TagV_way_select = w_fill & r_victim;
    assign bus.refill_done     = w_fill;
endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_refill_ctrl
// Description : Scoreboard bench for dcache_refill_ctrl with directed misses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_refill_ctrl;
    logic clk;
    logic rstn;

    dcache_refill_ctrl_if #(.ADDR_WIDTH(4), .TAG_WIDTH(25), .WORD_W(1), .WAY(2)) bus ();

    dcache_refill_ctrl #(.ADDR_WIDTH(4), .TAG_WIDTH(25), .LINE_WORDS(2), .WAY(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic        off;
        logic [31:0] din;
        logic        way;
    } dexp_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [25:0] din;
        logic        way;
    } texp_t;

    dexp_t       dataQ[$];
    texp_t       tagQ[$];
    logic [31:0] reqQ[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every DUT write/request must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.data_we) begin
            if (dataQ.size() == 0) check("unexpected_data_we", bus.data_we, 0);
            else begin
                dexp_t e;
                e = dataQ.pop_front();
                check("data_addr", bus.data_addr, e.addr);
                check("data_offset", bus.data_offset, e.off);
                check("data_din", bus.data_din, e.din);
                check("data_way", bus.data_way_select, e.way);
            end
        end
        if (bus.TagV_we) begin
            if (tagQ.size() == 0) check("unexpected_tagv_we", bus.TagV_we, 0);
            else begin
                texp_t t;
                t = tagQ.pop_front();
                check("tagv_addr", bus.TagV_addr_write, t.idx);
                check("tagv_din", bus.TagV_din_write, t.din);
                check("tagv_way", bus.TagV_way_select, t.way);
                check("refill_done", bus.refill_done, 1);
            end
        end else if (bus.refill_done) begin
            check("refill_done_without_tagv", bus.refill_done, 0);
        end
        if (bus.mem_rd_req && bus.mem_rd_ready) begin
            if (reqQ.size() == 0) check("unexpected_mem_req", bus.mem_rd_req, 0);
            else check("mem_rd_addr_accept", bus.mem_rd_addr, reqQ.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete miss; the LRU model's victim is supplied as expWay.
    // poke drives ignored lookups at pokeIdx during the inter-word gap.
    task automatic do_miss(input logic [3:0] idx, input logic [24:0] tg, input logic expWay,
                           input int readyDelay, input int gap,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input bit poke, input logic [3:0] pokeIdx);
        logic [31:0] a;
        a = {tg, idx, 3'b000};
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_tag   = tg;
        bus.hit       = 2'b00;
        #1;
        check("stall_same_cycle", bus.stall, 1);
        check("no_req_in_idle", bus.mem_rd_req, 0);
        reqQ.push_back(a);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < readyDelay; i++) begin
            check("mem_rd_req_held", bus.mem_rd_req, 1);
            check("mem_rd_addr_stable", bus.mem_rd_addr, a);
            tick();
        end
        check("mem_rd_req_before_accept", bus.mem_rd_req, 1);
        bus.mem_rd_ready = 1'b1;
        tick();
        bus.mem_rd_ready = 1'b0;
        check("req_dropped_in_recv", bus.mem_rd_req, 0);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = w0;
        dataQ.push_back('{addr: idx, off: 1'b0, din: w0, way: expWay});
        tick();
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'hDEADBEEF;
        for (int g = 0; g < gap; g++) begin
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_index = pokeIdx;
                bus.req_tag   = 25'h1FFFFFF;
                bus.hit       = (g == 0) ? 2'b01 : 2'b00;
            end
            tick();
            bus.req_valid = 1'b0;
            bus.hit       = 2'b00;
        end
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = w1;
        dataQ.push_back('{addr: idx, off: 1'b1, din: w1, way: expWay});
        tagQ.push_back('{idx: idx, din: {1'b1, tg}, way: expWay});
        tick();
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'hDEADBEEF;
        check("stall_in_fill", bus.stall, 1);
        tick();
        check("stall_after_fill", bus.stall, 0);
        check("no_req_after_fill", bus.mem_rd_req, 0);
    endtask

    task automatic hit_lookup(input logic [3:0] idx, input logic [1:0] h);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_tag   = 25'h0;
        bus.hit       = h;
        #1;
        check("stall_on_hit", bus.stall, 0);
        tick();
        bus.req_valid = 1'b0;
        bus.hit       = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rstn             = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_index    = '0;
        bus.req_tag      = '0;
        bus.hit          = 2'b00;
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_rd_req", bus.mem_rd_req, 0);
        check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        check("rst_data_we", bus.data_we, 0);
        check("rst_data_din", bus.data_din, 0);
        check("rst_tagv_we", bus.TagV_we, 0);
        check("rst_refill_done", bus.refill_done, 0);
        check("rst_stall_idle", bus.stall, 0);
        bus.req_valid = 1'b1;
        #1;
        check("rst_stall_follows_miss", bus.stall, 1);
        bus.req_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // First miss: LRU reset value selects way 0; slow memory, gapped words.
        do_miss(4'd3, 25'h0ABCDEF, 1'b0, 5, 2, 32'h11111111, 32'h22222222, 1'b0, 4'd0);
        // Same set again: LRU now points at way 1; memory accepts immediately.
        do_miss(4'd3, 25'h1111111, 1'b1, 0, 0, 32'h33333333, 32'h44444444, 1'b0, 4'd0);

        // Hit on way 1 makes way 0 the victim.
        hit_lookup(4'd5, 2'b10);
        do_miss(4'd5, 25'h0055555, 1'b0, 1, 1, 32'h55555555, 32'h66666666, 1'b0, 4'd0);
        // After that fill way 1 is victim; a multi-hit counts as way 1 -> victim 0.
        hit_lookup(4'd5, 2'b11);
        do_miss(4'd5, 25'h0066666, 1'b0, 0, 1, 32'h77777777, 32'h88888888, 1'b0, 4'd0);

        // Return data while idle must be ignored.
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hCAFEF00D;
        tick();
        tick();
        bus.mem_rd_valid = 1'b0;
        tick();
        check("idle_no_req", bus.mem_rd_req, 0);

        // Lookups during RECV at set 10 must not touch its LRU bit.
        do_miss(4'd9, 25'h0099999, 1'b0, 0, 2, 32'h99999999, 32'hAAAAAAAA, 1'b1, 4'd10);
        do_miss(4'd10, 25'h00AAAAA, 1'b0, 0, 0, 32'hBBBBBBBB, 32'hCCCCCCCC, 1'b0, 4'd0);

        // Reset in the middle of RECV after one word.
        bus.req_valid = 1'b1;
        bus.req_index = 4'd7;
        bus.req_tag   = 25'h1234567;
        bus.hit       = 2'b00;
        reqQ.push_back({25'h1234567, 4'd7, 3'b000});
        tick();
        bus.req_valid    = 1'b0;
        bus.mem_rd_ready = 1'b1;
        tick();
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hAAAA5555;
        dataQ.push_back('{addr: 4'd7, off: 1'b0, din: 32'hAAAA5555, way: 1'b0});
        tick();
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'hDEADBEEF;
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_data_we", bus.data_we, 0);
        check("abort_data_din", bus.data_din, 0);
        check("abort_mem_rd_req", bus.mem_rd_req, 0);
        check("abort_tagv_we", bus.TagV_we, 0);
        check("abort_refill_done", bus.refill_done, 0);
        check("abort_stall", bus.stall, 0);
        tick();
        rstn = 1'b1;
        tick();
        do_miss(4'd7, 25'h1234567, 1'b0, 2, 0, 32'hDDDDDDDD, 32'hEEEEEEEE, 1'b0, 4'd0);

        tick();
        tick();
        check("data_queue_drained", dataQ.size(), 0);
        check("tag_queue_drained", tagQ.size(), 0);
        check("req_queue_drained", reqQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Miss handler and replacement unit directly downstream of the Dcache tag/valid array.
- Consumes the per-way hit vector from the lookup stage and keeps a per-set LRU bit.
- On a miss it stalls the pipeline, fetches the line from memory, writes the data words into the data array, then writes {valid, tag} back into the tag/valid array for the victim way.
- The cache is write-through, so there is no dirty state and no writeback.

Parameters:
- addr_width, 4, set index width (2^addr_width sets)
- tag_width, 25, tag width; tag_width + addr_width + offset_width = 32
- line_words, 2, 32-bit words per line (power of two); offset_width = log2(line_words*4) = 3
- way, 2, associativity; fixed at 2 for this block

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  lookup stage holds a valid load/store this cycle
- req_index  in  addr_width  set index of the request
- req_tag  in  tag_width  tag of the request
- hit  in  way  per-way hit vector from the tag/valid array
- stall  out  1  freeze the lookup stage
- mem_rd_req  out  1  line-read request to memory
- mem_rd_addr  out  32  line-aligned address {tag, index, offset_width'b0}
- mem_rd_ready  in  1  memory accepts the request
- mem_rd_valid  in  1  one return word valid
- mem_rd_data  in  32  return word
- data_we  out  1  data-array write enable
- data_addr  out  addr_width  data-array set index
- data_offset  out  log2(line_words)  word index within the line
- data_din  out  32  data-array write data (mem_rd_data registered through)
- data_way_select  out  1  victim way for the data write
- TagV_we  out  1  tag/valid write enable
- TagV_addr_write  out  addr_width  tag/valid write index
- TagV_din_write  out  tag_width+1  {1'b1, tag}
- TagV_way_select  out  1  victim way for the tag write
- refill_done  out  1  one-cycle pulse when the line is installed

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; all LRU bits 0; word counter 0; latched index/tag 0. Every output is 0 except stall, which follows its combinational equation.
- States: IDLE, REQ, RECV, FILL.
- stall = (state != IDLE) | (state == IDLE & req_valid & hit == 0). Combinational, so stall rises in the same cycle the miss is seen.
- IDLE, req_valid & |hit:
  - used way = hit[1] ? 1 : 0. A multi-hit resolves to way 1.
  - lru[req_index] <= ~used. The LRU bit names the victim way.
  - Stay in IDLE.
- IDLE, req_valid & hit == 0:
  - Latch index, tag, and victim = lru[req_index].
  - counter <= 0; go to REQ.
- REQ:
  - mem_rd_req=1 with a stable mem_rd_addr until mem_rd_ready is sampled high in the same cycle; then go to RECV.
  - mem_rd_req must not drop before acceptance.
- RECV:
  - Each cycle with mem_rd_valid=1 registers a data write on the next cycle: data_we=1, data_offset=counter, data_din=mem_rd_data, data_addr=latched index, data_way_select=victim. Then counter++.
  - Cycles without mem_rd_valid produce no write and leave the counter unchanged.
  - When the word with counter == line_words-1 is accepted, go to FILL.
- FILL, exactly one cycle:
  - Outputs: TagV_we=1, TagV_addr_write=latched index, TagV_din_write={1'b1, tag}, TagV_way_select=victim, refill_done=1.
  - lru[index] <= ~victim.
  - The last data write (registered) is also active in this cycle.
  - Go to IDLE.
- The cycle after FILL is IDLE. stall drops unless the replayed lookup misses again; the replayed lookup must now hit.
- mem_rd_valid outside RECV is ignored. req_valid/hit outside IDLE are ignored, and LRU is not updated.
- Counter wrap: after line_words words the counter returns to 0.
- Reset mid-refill: abort immediately to IDLE.
  - No TagV write happens, so the set stays in its previous tag/valid state.
  - A partially written data line is harmless because its valid bit was never set.
- Latency: miss to mem_rd_req is 1 cycle. Last word to TagV_we is 1 cycle. Minimum miss penalty is 2 + line_words + memory latency cycles.

Test Plan:
- Reset, then req_valid=1, index=3, hit=2'b00, tag=0x0ABCDEF:
  - stall=1 the same cycle; mem_rd_req=1 next cycle with mem_rd_addr={0x0ABCDEF, 4'h3, 3'b0}.
  - Victim is way 0 (LRU reset value).
- Memory-side variations:
  - Hold mem_rd_ready=0 for 5 cycles → mem_rd_req stays 1 and the address is stable.
  - Ready=1 → REQ exits after 1 cycle.
  - Words 0x11111111 and 0x22222222 with a 2-cycle gap → data_we pulses at offsets 0 and 1 carrying those values, and nothing is written in the gap.
- After the last word:
  - Next cycle: TagV_we=1, TagV_din_write={1, 0x0ABCDEF}, way 0, index 3, refill_done=1.
  - The following cycle stall=0.
  - A second miss on index 3 picks way 1.
- Hit update:
  - req_valid with hit=2'b10 at index 5 → LRU[5]=0; a subsequent miss at 5 refills way 0.
  - hit=2'b11 at index 5 → treated as way 1, so LRU[5]=0.
- Assert rstn=0 while in RECV after 1 of 2 words:
  - All outputs go to 0 asynchronously, no TagV_we ever fires, and state returns to IDLE.
  - Replaying the same miss restarts from REQ.
- mem_rd_valid pulses while in IDLE, and req_valid with a miss during RECV → no data_we, no LRU change, no new request.
